// File: rtl/alu_seq.sv
// ============================================================================
// alu_seq : handshaked ALU with logic/arith/shift ops and iterative multiply
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_seq #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       sel,
   input  logic             Cin,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] Y,
   output logic             Cout,
   output logic             Negative,
   output logic             Zero,
   output logic             Overflow,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_NOTA = 4'b0010;
   localparam logic [3:0] OP_NOR  = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NAND = 4'b0101;
   localparam logic [3:0] OP_ADD  = 4'b0110;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_SHL  = 4'b1000;
   localparam logic [3:0] OP_SHR  = 4'b1001;
   localparam logic [3:0] OP_SRA  = 4'b1010;
   localparam logic [3:0] OP_MUL  = 4'b1011;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               cout_q, cout_d;
   logic               neg_q, neg_d;
   logic               zero_q, zero_d;
   logic               ovf_q, ovf_d;

   logic [WIDTH-1:0]   alu_y;
   logic               alu_c;
   logic               alu_v;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [SHW-1:0]     sh;
   logic [2*WIDTH-1:0] acc_step;

   assign sh = B[SHW-1:0];

   // Single-cycle ops are evaluated straight off the inputs and captured at accept.
   always_comb begin
      alu_y   = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      sum     = '0;
      shl_ext = '0;
      shr_ext = '0;
      case (sel)
         OP_AND:  alu_y = A & B;
         OP_OR:   alu_y = A | B;
         OP_NOTA: alu_y = ~A;
         OP_NOR:  alu_y = ~(A | B);
         OP_XOR:  alu_y = A ^ B;
         OP_NAND: alu_y = ~(A & B);
         OP_ADD: begin
            sum   = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, Cin};
            alu_y = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = A[WIDTH-1] ^ B[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
         end
         OP_SUB: begin
            sum   = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
            alu_y = sum[WIDTH-1:0];
            alu_c = sum[WIDTH];
            alu_v = A[WIDTH-1] ^ ~B[WIDTH-1] ^ sum[WIDTH-1] ^ sum[WIDTH];
         end
         // The extra guard bit catches the last bit shifted out (0 when sh=0).
         OP_SHL: begin
            shl_ext = {1'b0, A} << sh;
            alu_y   = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            shr_ext = {A, 1'b0} >> sh;
            alu_y   = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         OP_SRA: begin
            shr_ext = $unsigned($signed({A, 1'b0}) >>> sh);
            alu_y   = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         default: ;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      y_d      = y_q;
      cout_d   = cout_q;
      neg_d    = neg_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               if (sel == OP_MUL) begin
                  mcand_d  = {{WIDTH{1'b0}}, A};
                  mplier_d = B;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_BUSY;
               end else begin
                  y_d     = alu_y;
                  cout_d  = alu_c;
                  ovf_d   = alu_v;
                  neg_d   = alu_y[WIDTH-1];
                  zero_d  = (alu_y == '0);
                  state_d = S_DONE;
               end
            end
         end
         S_BUSY: begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH-1)) begin
               y_d     = acc_step[WIDTH-1:0];
               cout_d  = 1'b0;
               ovf_d   = |acc_step[2*WIDTH-1:WIDTH];
               neg_d   = acc_step[WIDTH-1];
               zero_d  = (acc_step[WIDTH-1:0] == '0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         y_q      <= '0;
         cout_q   <= 1'b0;
         neg_q    <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         y_q      <= y_d;
         cout_q   <= cout_d;
         neg_q    <= neg_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign Y         = y_q;
   assign Cout      = cout_q;
   assign Negative  = neg_q;
   assign Zero      = zero_q;
   assign Overflow  = ovf_q;

endmodule

`default_nettype wire
